// File: rtl/cdb_grant_arbiter.sv
// Common-data-bus arbiter: rotating-priority grant of NUM_CDB ports among NUM_REQ result sources,
// with a registered CDB broadcast. Define CDB_STARVE_GUARD_EN to build the starvation guard.
module cdb_grant_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int NUM_CDB      = 3,
    parameter int TAG_W        = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mispredict,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]  rr_ptr_dbg
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int PSEL_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    // Handshake: req[i] is the valid of source i and grant[i] is its ready, in the same cycle.
    // A granted source is consumed and must drop or replace req next cycle; a denied source holds
    // req, tag and data stable until granted.

    logic                 kill;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   starved;
    logic [NUM_CDB-1:0]   port_valid;
    logic [TAG_W-1:0]     port_tag  [NUM_CDB];
    logic [DATA_W-1:0]    port_data [NUM_CDB];
    logic [PTR_W-1:0]     idx;
    int                   n_granted;

    assign kill       = reset || mispredict;
    assign rr_ptr_dbg = rr_ptr;

`ifdef CDB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] wait_cnt [NUM_REQ];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (kill || grant[i] || !req[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end
`else
    assign starved = '0;
`endif

    // Pass 0 scans starved sources, pass 1 the rest, both starting at rr_ptr. The pointer ends
    // one past the last winner, so a non-starved winner overrides a starved one.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        ptr_next   = rr_ptr;
        n_granted  = 0;
        idx        = '0;
        for (int n = 0; n < NUM_CDB; n++) begin
            port_tag[n]  = '0;
            port_data[n] = '0;
        end
        if (!kill) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
                    if (req[idx] && (starved[idx] == (pass == 0)) && (n_granted < NUM_CDB)) begin
                        grant[idx]                    = 1'b1;
                        port_valid[PSEL_W'(n_granted)] = 1'b1;
                        port_tag[PSEL_W'(n_granted)]   = req_tag[idx*TAG_W +: TAG_W];
                        port_data[PSEL_W'(n_granted)]  = req_data[idx*DATA_W +: DATA_W];
                        ptr_next                      = PTR_W'((int'(idx) + 1) % NUM_REQ);
                        n_granted                     = n_granted + 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (kill) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            rr_ptr    <= ptr_next;
            cdb_valid <= port_valid;
            for (int n = 0; n < NUM_CDB; n++) begin
                cdb_tag[n*TAG_W +: TAG_W]    <= port_tag[n];
                cdb_data[n*DATA_W +: DATA_W] <= port_data[n];
            end
        end
    end

endmodule
